// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t     : arbiter FSM states (IDLE, OWN0, OWN1)
//   ADDR_W_DEF  : default word-address width
//   DATA_W_DEF  : default word width
//   PORT0/PORT1 : port index encoding used for rr_last and the grant index
//   CNT_MAX     : saturation value of the 8-bit burst counter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req0, req1 : requests
//   rr_last    : index of the port granted most recently
//   pick       : one-hot choice (bit 0 = port 0, bit 1 = port 1), zero if no request
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       rr_last,
    output logic [1:0] pick
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pick = 2'b00;
        if (req0 && req1) begin
            // On a tie the port that did not win last time goes next.
            pick = (rr_last == PORT1) ? 2'b01 : 2'b10;
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port word memory between instruction fetch
// (port 0) and load/store (port 1). Round-robin on ties, optional locked
// bursts bounded by MAX_BURST while the other port waits.
//   clk, rst_n              : clock, asynchronous active-low reset
//   reqN/weN/lockN          : per-port request, write enable, burst lock
//   addrN/wdataN            : per-port word address and write data
//   gntN                    : combinational; access performed this cycle
//   rvalidN                 : registered; rdata holds a read granted last cycle
//   rdata                   : registered read data, shared by both ports
//   mem_addr/mem_wdata/mem_we/mem_rdata : memory interface (async read)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    state_t     state, state_next;
    logic       rr_last, rr_next;
    logic [7:0] burst_cnt, cnt_next;

    logic [1:0] pick;
    logic       gnt_any;   // FSM wants to grant this cycle
    logic       gnt_idx;   // which port it grants
    logic       gnt_ok;    // grant qualified by reset
    logic       own;       // owner index while in OWN0/OWN1
    logic       req_own, lock_own, req_other;
    logic       rd0, rd1;

    rr_pick2 u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last),
        .pick    (pick)
    );

    assign own       = (state == OWN1);
    assign req_own   = own ? req1  : req0;
    assign lock_own  = own ? lock1 : lock0;
    assign req_other = own ? req0  : req1;

    always_comb begin
        state_next = state;
        rr_next    = rr_last;
        cnt_next   = burst_cnt;
        gnt_any    = 1'b0;
        gnt_idx    = PORT0;

        case (state)
            IDLE: begin
                gnt_any = |pick;
                gnt_idx = pick[1];
                if (gnt_any) begin
                    if (gnt_idx ? lock1 : lock0) begin
                        state_next = gnt_idx ? OWN1 : OWN0;
                        cnt_next   = 8'd1;
                    end else begin
                        cnt_next   = 8'd0;
                    end
                end
            end

            default: begin
                // Starvation bound is checked first so a waiting port never
                // sees more than MAX_BURST owner beats in a row.
                if (burst_cnt >= MAX_BURST_C && req_other) begin
                    gnt_any    = 1'b1;
                    gnt_idx    = ~own;
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else if (req_own && lock_own) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = own;
                    cnt_next = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + 8'd1;
                end else if (req_own) begin
                    // Final beat of the burst.
                    gnt_any    = 1'b1;
                    gnt_idx    = own;
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    // Owner released: the other port may use this cycle.
                    gnt_any    = req_other;
                    gnt_idx    = ~own;
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end
            end
        endcase

        if (gnt_any) begin
            rr_next = gnt_idx;
        end
    end

    // Grants are suppressed combinationally while reset is asserted.
    assign gnt_ok    = gnt_any & rst_n;
    assign gnt0      = gnt_ok & (gnt_idx == PORT0);
    assign gnt1      = gnt_ok & (gnt_idx == PORT1);

    assign mem_addr  = gnt1 ? addr1  : addr0;
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign mem_we    = (gnt0 & we0) | (gnt1 & we1);

    assign rd0 = gnt0 & ~we0;
    assign rd1 = gnt1 & ~we1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= PORT1;
            burst_cnt <= 8'd0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            // NOTE: rdata is a single register, not a memory array, so resetting it is cheap and required.
            rdata     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state     <= state_next;
            rr_last   <= rr_next;
            burst_cnt <= cnt_next;
            rvalid0   <= rd0;
            rvalid1   <= rd1;
            if (rd0 || rd1) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
